uart_boot_loader: RTL and testbench

Sequencer between the UART byte-stream controller and the core. After reset it owns both UART streams and holds the core in reset. It receives a length-prefixed program image from the host and writes it word by word into instruction memory. It then acknowledges the host and hands the UART streams to the core through a combinational pass-through.

---
 rtl/uart_boot_loader.sv | 188 ++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: owns the UART byte streams after reset, receives a length-prefixed
// program image, writes it word by word into instruction memory, acknowledges the host
// and then hands both streams to the core through a combinational pass-through.
module uart_boot_loader #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter logic [7:0]  ACK_BYTE   = 8'hAA,
   parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  core_reset_o,
   output logic                  loading_o,
   output logic                  error_o,
   output logic                  imem_we_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   output logic [31:0]           imem_wdata_o,
   output logic                  ctl_out_valid_o,
   input  logic [7:0]            ctl_out_data_i,
   input  logic                  ctl_out_ready_i,
   output logic                  ctl_in_valid_o,
   output logic [7:0]            ctl_in_data_o,
   input  logic                  ctl_in_ready_i,
   input  logic                  core_out_valid_i,
   output logic [7:0]            core_out_data_o,
   output logic                  core_out_ready_o,
   input  logic                  core_in_valid_i,
   input  logic [7:0]            core_in_data_i,
   output logic                  core_in_ready_o
);

   // One extra bit so a count of exactly 2**32-1 still compares correctly.
   localparam logic [32:0] Capacity = 33'd1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      StLen,
      StData,
      StSendAck,
      StSendErr,
      StRun,
      StHalt
   } state_e;

   state_e                state_q, state_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [31:0]           count_q, count_d;
   logic [31:0]           remaining_q, remaining_d;
   logic [31:0]           word_q, word_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  error_q, error_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [31:0]           wdata_q, wdata_d;

   // Little-endian assembly: each new byte enters at the top and older bytes shift down.
   logic [31:0] count_full;
   logic [31:0] word_full;
   assign count_full = {ctl_out_data_i, count_q[31:8]};
   assign word_full  = {ctl_out_data_i, word_q[31:8]};

   // State and datapath registers, synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StLen;
         byte_cnt_q  <= 2'd0;
         count_q     <= 32'd0;
         remaining_q <= 32'd0;
         word_q      <= 32'd0;
         addr_q      <= '0;
         error_q     <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         count_q     <= count_d;
         remaining_q <= remaining_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         error_q     <= error_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
      end
   end

   // Next-state logic: length capture, word assembly and the write strobe.
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      count_d     = count_q;
      remaining_d = remaining_q;
      word_d      = word_q;
      addr_d      = addr_q;
      error_d     = error_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      unique case (state_q)
         StLen: begin
            if (ctl_out_ready_i) begin
               count_d    = count_full;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (count_full == 32'd0) begin
                     state_d = StSendAck;
                  end else if ({1'b0, count_full} > Capacity) begin
                     state_d = StSendErr;
                     error_d = 1'b1;
                  end else begin
                     state_d     = StData;
                     remaining_d = count_full;
                     addr_d      = '0;
                  end
               end
            end
         end
         StData: begin
            if (ctl_out_ready_i) begin
               word_d     = word_full;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  we_d        = 1'b1;
                  waddr_d     = addr_q;
                  wdata_d     = word_full;
                  remaining_d = remaining_q - 32'd1;
                  // Hold the address on the last word so a full image never wraps it.
                  if (remaining_q == 32'd1) begin
                     state_d = StSendAck;
                  end else begin
                     addr_d = addr_q + 1'b1;
                  end
               end
            end
         end
         StSendAck: begin
            if (ctl_in_ready_i) state_d = StRun;
         end
         StSendErr: begin
            if (ctl_in_ready_i) state_d = StHalt;
         end
         StRun, StHalt: begin
         end
         default: state_d = StLen;
      endcase
   end

   // Stream ownership: loader handshakes outside RUN, straight wires to the core in RUN.
   always_comb begin
      ctl_out_valid_o  = 1'b0;
      ctl_in_valid_o   = 1'b0;
      ctl_in_data_o    = 8'd0;
      core_out_data_o  = 8'd0;
      core_out_ready_o = 1'b0;
      core_in_ready_o  = 1'b0;
      if (!reset) begin
         unique case (state_q)
            StLen, StData: ctl_out_valid_o = 1'b1;
            StSendAck: begin
               ctl_in_valid_o = 1'b1;
               ctl_in_data_o  = ACK_BYTE;
            end
            StSendErr: begin
               ctl_in_valid_o = 1'b1;
               ctl_in_data_o  = ERR_BYTE;
            end
            StRun: begin
               ctl_out_valid_o  = core_out_valid_i;
               core_out_data_o  = ctl_out_data_i;
               core_out_ready_o = ctl_out_ready_i;
               ctl_in_valid_o   = core_in_valid_i;
               ctl_in_data_o    = core_in_data_i;
               core_in_ready_o  = ctl_in_ready_i;
            end
            default: begin
            end
         endcase
      end
   end

   assign core_reset_o = (state_q != StRun);
   assign loading_o    = (state_q != StRun);
   assign error_o      = error_q;
   assign imem_we_o    = we_q;
   assign imem_addr_o  = waddr_q;
   assign imem_wdata_o = wdata_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: drives random and directed program images through a controller
// model and checks every cycle against an image-level reference of the load protocol.
module tb_uart_boot_loader;

   localparam int unsigned AW  = 4;
   localparam longint      Cap = 64'd1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          core_reset, loading, error;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          ctl_out_valid, ctl_out_ready;
   logic [7:0]    ctl_out_data;
   logic          ctl_in_valid, ctl_in_ready;
   logic [7:0]    ctl_in_data;
   logic          core_out_valid, core_out_ready;
   logic [7:0]    core_out_data;
   logic          core_in_valid, core_in_ready;
   logic [7:0]    core_in_data;

   always #5 clk = ~clk;

   uart_boot_loader #(
      .ADDR_WIDTH (AW),
      .ACK_BYTE   (8'hAA),
      .ERR_BYTE   (8'hEE)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .core_reset_o     (core_reset),
      .loading_o        (loading),
      .error_o          (error),
      .imem_we_o        (imem_we),
      .imem_addr_o      (imem_addr),
      .imem_wdata_o     (imem_wdata),
      .ctl_out_valid_o  (ctl_out_valid),
      .ctl_out_data_i   (ctl_out_data),
      .ctl_out_ready_i  (ctl_out_ready),
      .ctl_in_valid_o   (ctl_in_valid),
      .ctl_in_data_o    (ctl_in_data),
      .ctl_in_ready_i   (ctl_in_ready),
      .core_out_valid_i (core_out_valid),
      .core_out_data_o  (core_out_data),
      .core_out_ready_o (core_out_ready),
      .core_in_valid_i  (core_in_valid),
      .core_in_data_i   (core_in_data),
      .core_in_ready_o  (core_in_ready)
   );

   int checks   = 0;
   int failures = 0;

   // Host/controller model and image-level expectations.
   logic [7:0]  host_q[$];
   logic [7:0]  sent_q[$];
   logic [31:0] wr_log[$];
   int          consumed;
   int          pulse_idx_prev;
   bit          pulse_prev;
   bit          resp_done;
   int          wr_count;
   int          gap;
   logic [7:0]  last_resp;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] load_count();
      return {sent_q[3], sent_q[2], sent_q[1], sent_q[0]};
   endfunction

   function automatic bit is_over();
      return consumed >= 4 && longint'({32'd0, load_count()}) > Cap;
   endfunction

   // Total bytes the loader should consume for the image seen so far.
   function automatic longint needed();
      longint c;
      if (consumed < 4) return 4;
      c = longint'({32'd0, load_count()});
      if (c == 0 || c > Cap) return 4;
      return 4 + 4 * c;
   endfunction

   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) host_q.push_back(w[8*i +: 8]);
   endtask

   task automatic push_load(input logic [31:0] cnt, input int extra);
      push_word(cnt);
      if (cnt != 0 && longint'({32'd0, cnt}) <= Cap)
         for (int i = 0; i < 4 * int'(cnt); i++) host_q.push_back(8'($urandom));
      for (int i = 0; i < extra; i++) host_q.push_back(8'($urandom));
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      ctl_out_ready  = 1'b0;
      ctl_out_data   = 8'd0;
      ctl_in_ready   = 1'b0;
      core_out_valid = 1'b0;
      core_in_valid  = 1'b0;
      core_in_data   = 8'd0;
      repeat (2) @(negedge clk);
      check_eq("rst.core_reset", core_reset, 1);
      check_eq("rst.loading", loading, 1);
      check_eq("rst.error", error, 0);
      check_eq("rst.imem_we", imem_we, 0);
      check_eq("rst.imem_addr", imem_addr, 0);
      check_eq("rst.imem_wdata", imem_wdata, 0);
      check_eq("rst.ctl_in_valid", ctl_in_valid, 0);
      check_eq("rst.ctl_in_data", ctl_in_data, 0);
      check_eq("rst.ctl_out_valid", ctl_out_valid, 0);
      reset = 1'b0;
      host_q.delete();
      sent_q.delete();
      wr_log.delete();
      consumed       = 0;
      pulse_idx_prev = 0;
      pulse_prev     = 1'b0;
      resp_done      = 1'b0;
      wr_count       = 0;
      gap            = 0;
      last_resp      = 8'd0;
   endtask

   // One cycle: compare outputs with the image model, then act as controller.
   task automatic env_cycle();
      bit          exp_we, running, over, drove;
      logic [31:0] exp_word;
      int          i;
      @(negedge clk);
      over    = is_over();
      running = resp_done && !over;
      exp_we  = pulse_prev && pulse_idx_prev >= 4 && ((pulse_idx_prev - 4) % 4 == 3);
      check_eq("imem_we", imem_we, exp_we);
      if (exp_we) begin
         i        = pulse_idx_prev;
         exp_word = {sent_q[i], sent_q[i-1], sent_q[i-2], sent_q[i-3]};
         check_eq("imem_addr", imem_addr, (i - 4) / 4);
         check_eq("imem_wdata", imem_wdata, exp_word);
      end
      if (imem_we) begin
         wr_count++;
         wr_log.push_back(imem_wdata);
      end
      check_eq("ctl_out_valid", ctl_out_valid, longint'(consumed) < needed());
      check_eq("ctl_in_valid", ctl_in_valid,
               consumed >= 4 && longint'(consumed) == needed() && !resp_done);
      if (consumed >= 4 && longint'(consumed) == needed() && !resp_done)
         check_eq("ctl_in_data", ctl_in_data, over ? 8'hEE : 8'hAA);
      check_eq("core_reset", core_reset, !running);
      check_eq("loading", loading, !running);
      check_eq("error", error, over);
      if (!running) begin
         check_eq("core_out_ready", core_out_ready, 0);
         check_eq("core_in_ready", core_in_ready, 0);
         check_eq("core_out_data", core_out_data, 0);
      end
      // Controller side: at most one byte every two cycles, random extra gaps.
      ctl_out_ready = 1'b0;
      ctl_in_ready  = 1'b0;
      ctl_out_data  = 8'($urandom);
      drove         = 1'b0;
      if (!pulse_prev && ctl_out_valid && host_q.size() > 0) begin
         if (gap > 0) begin
            gap--;
         end else begin
            ctl_out_ready  = 1'b1;
            ctl_out_data   = host_q.pop_front();
            sent_q.push_back(ctl_out_data);
            pulse_idx_prev = consumed;
            consumed++;
            drove = 1'b1;
            gap   = $urandom_range(0, 2);
         end
      end
      pulse_prev = drove;
      if (ctl_in_valid && !resp_done && $urandom_range(0, 2) == 0) begin
         ctl_in_ready = 1'b1;
         resp_done    = 1'b1;
         last_resp    = ctl_in_data;
      end
   endtask

   task automatic run_load(input string tag, input logic [31:0] cnt, input int extra);
      int c = 0;
      int exp_writes;
      exp_writes = (cnt != 0 && longint'({32'd0, cnt}) <= Cap) ? int'(cnt) : 0;
      while (!resp_done && c < 3000) begin
         env_cycle();
         c++;
      end
      check_eq({tag, ".responded"}, resp_done, 1);
      repeat (12) env_cycle();
      check_eq({tag, ".writes"}, wr_count, exp_writes);
      check_eq({tag, ".unread"}, host_q.size(), extra);
   endtask

   initial begin
      logic [31:0] cnt;
      int          r, c;
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Two-word image.
      do_reset();
      push_word(32'd2);
      push_word(32'h12345678);
      push_word(32'hDEADBEEF);
      run_load("two_words", 32'd2, 0);
      check_eq("two_words.w0", wr_log.size() > 0 ? wr_log[0] : 32'hx, 32'h12345678);
      check_eq("two_words.w1", wr_log.size() > 1 ? wr_log[1] : 32'hx, 32'hDEADBEEF);
      check_eq("two_words.ack", last_resp, 8'hAA);
      check_eq("two_words.core_reset", core_reset, 0);

      // Oversize by one word: rejected, halted, later bytes left unread.
      do_reset();
      push_load(32'h11, 4);
      run_load("oversize", 32'h11, 4);
      check_eq("oversize.err_byte", last_resp, 8'hEE);
      check_eq("oversize.error", error, 1);
      check_eq("oversize.core_reset", core_reset, 1);

      // Full capacity: last write lands on the top address.
      do_reset();
      push_load(32'h10, 2);
      run_load("full", 32'h10, 2);
      check_eq("full.ack", last_resp, 8'hAA);
      check_eq("full.last_addr", imem_addr, Cap - 1);

      // Reset mid-image, then a clean one-word reload.
      do_reset();
      push_word(32'd2);
      for (int i = 0; i < 3; i++) host_q.push_back(8'($urandom));
      c = 0;
      while (consumed < 7 && c < 500) begin
         env_cycle();
         c++;
      end
      check_eq("midreset.partial", consumed, 7);
      do_reset();
      push_word(32'd1);
      push_word(32'hCAFEF00D);
      run_load("reload", 32'd1, 0);
      check_eq("reload.word", wr_log.size() == 1 ? wr_log[0] : 32'hx, 32'hCAFEF00D);

      // Random images, including zero, capacity and huge unsigned counts.
      for (int n = 0; n < 8; n++) begin
         r = $urandom_range(0, 9);
         if (r < 6)       cnt = $urandom_range(1, int'(Cap));
         else if (r == 6) cnt = 32'd0;
         else if (r == 7) cnt = 32'(Cap) + 32'($urandom_range(1, 50));
         else if (r == 8) cnt = 32'h8000_0000 | $urandom;
         else             cnt = 32'(Cap);
         do_reset();
         r = $urandom_range(0, 5);
         push_load(cnt, r);
         run_load("random", cnt, r);
      end

      // Empty image, then the RUN pass-through.
      do_reset();
      push_load(32'd0, 0);
      run_load("empty", 32'd0, 0);
      check_eq("empty.ack", last_resp, 8'hAA);
      check_eq("empty.loading", loading, 0);
      @(negedge clk);
      core_in_valid = 1'b1;
      core_in_data  = 8'h41;
      #1;
      check_eq("run.ctl_in_valid", ctl_in_valid, 1);
      check_eq("run.ctl_in_data", ctl_in_data, 8'h41);
      check_eq("run.core_in_ready_lo", core_in_ready, 0);
      ctl_in_ready = 1'b1;
      #1;
      check_eq("run.core_in_ready_hi", core_in_ready, 1);
      @(negedge clk);
      ctl_in_ready   = 1'b0;
      core_in_valid  = 1'b0;
      core_out_valid = 1'b1;
      #1;
      check_eq("run.ctl_out_valid", ctl_out_valid, 1);
      ctl_out_data  = 8'h5A;
      ctl_out_ready = 1'b1;
      #1;
      check_eq("run.core_out_data", core_out_data, 8'h5A);
      check_eq("run.core_out_ready", core_out_ready, 1);
      @(negedge clk);
      ctl_out_ready  = 1'b0;
      core_out_valid = 1'b0;
      #1;
      check_eq("run.ctl_out_valid_lo", ctl_out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
